// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: multi-cycle shift/rotate unit.
// A request is latched when idle, and then the shift is applied 2 bits per cycle.
// One extra 1-bit step covers odd amounts. The result is then held in DONE until
// the consumer takes it.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  request handshake (ready == idle)
//   operand/amt     value to shift and shift amount
//   oper            00 rotl, 01 sll, 10 sra, 11 srl
//   out_valid/ready result handshake (valid only in DONE)
//   result          registered shifted value
//   busy            high whenever not idle
module iter_shift_ctrl #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP2 = 2'd1,
        STEP1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] rem_m2;
    logic [1:0]       op_q;

    // Apply one step of the latched operation: two bits when two=1, otherwise one bit.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                              input logic [1:0]       op,
                                              input logic             two);
        logic [WIDTH-1:0] s;
        s = r;
        if (two) begin
            case (op)
                2'b00:   s = {r[WIDTH-3:0], r[WIDTH-1:WIDTH-2]};
                2'b01:   s = {r[WIDTH-3:0], 2'b00};
                2'b10:   s = {{2{r[WIDTH-1]}}, r[WIDTH-1:2]};
                default: s = {2'b00, r[WIDTH-1:2]};
            endcase
        end else begin
            case (op)
                2'b00:   s = {r[WIDTH-2:0], r[WIDTH-1]};
                2'b01:   s = {r[WIDTH-2:0], 1'b0};
                2'b10:   s = {r[WIDTH-1], r[WIDTH-1:1]};
                default: s = {1'b0, r[WIDTH-1:1]};
            endcase
        end
        return s;
    endfunction

    assign rem_m2    = rem - AMT_W'(2);
    assign in_ready  = (state == IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (amt >= AMT_W'(2))      state_nxt = STEP2;
                    else if (amt == AMT_W'(1)) state_nxt = STEP1;
                    else                       state_nxt = DONE;
                end
            end
            STEP2: begin
                if (rem_m2 >= AMT_W'(2))      state_nxt = STEP2;
                else if (rem_m2 == AMT_W'(1)) state_nxt = STEP1;
                else                          state_nxt = DONE;
            end
            STEP1:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: result, remaining count and latched opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            rem    <= '0;
            op_q   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        result <= operand;
                        rem    <= amt;
                        op_q   <= oper;
                    end
                end
                STEP2: begin
                    result <= step(result, op_q, 1'b1);
                    rem    <= rem_m2;
                end
                STEP1: begin
                    result <= step(result, op_q, 1'b0);
                    rem    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Self-checking bench for iter_shift_ctrl.
// The bench runs directed vector tables, the multi-cycle corner cases, and random
// requests. Random requests are checked against an arithmetic reference model.
module tb_iter_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] operand;
    logic [3:0]  amt;
    logic [1:0]  oper;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int tests = 0;
    int fails = 0;

    iter_shift_ctrl #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand(operand), .amt(amt), .oper(oper), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op_v;
        logic [3:0]  a;
        logic [1:0]  o;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: shift rules expressed as whole-amount arithmetic.
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input int a, input logic [1:0] o);
        logic [31:0]        u;
        logic signed [31:0] s;
        u = {16'b0, x};
        s = $signed({{16{x[15]}}, x});
        case (o)
            2'b00:   ref_shift = 16'((u << a) | (u >> (16 - a)));
            2'b01:   ref_shift = 16'(u << a);
            2'b10:   ref_shift = 16'(s >>> a);
            default: ref_shift = 16'(u >> a);
        endcase
    endfunction

    // Issue one request, measure latency, check result, then consume it.
    task automatic do_op(input logic [15:0] op_v, input logic [3:0] a, input logic [1:0] o,
                         input logic [15:0] exp, input int exp_lat, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, "_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; operand = op_v; amt = a; oper = o; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_res"}, {16'b0, result}, {16'b0, exp});
        chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_ovdrop"}, {31'b0, out_valid}, 32'd0);
        chk({nm, "_idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] rx;
        int          ra;
        logic [1:0]  ro;
        logic        seen;

        vecs[0] = '{16'h8001, 4'd1,  2'b00, 16'h0003, 2};
        vecs[1] = '{16'h1234, 4'd4,  2'b00, 16'h2341, 3};
        vecs[2] = '{16'h00FF, 4'd5,  2'b01, 16'h1FE0, 4};
        vecs[3] = '{16'h8000, 4'd15, 2'b11, 16'h0001, 9};
        vecs[4] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 9};
        vecs[5] = '{16'h7FF0, 4'd4,  2'b10, 16'h07FF, 3};
        vecs[6] = '{16'hBEEF, 4'd0,  2'b01, 16'hBEEF, 1};
        vecs[7] = '{16'h1357, 4'd0,  2'b10, 16'h1357, 1};

        rst = 1'b1; in_valid = 1'b0; operand = '0; amt = '0; oper = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].op_v, vecs[i].a, vecs[i].o, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        // Backpressure: hold the result with out_ready low while a new request waits.
        do_op(16'hF0F0, 4'd3, 2'b11, 16'h1E1E, 3, "bp_warm");
        @(negedge clk);
        in_valid = 1'b1; operand = 16'hF0F0; amt = 4'd3; oper = 2'b11;
        @(posedge clk);
        #1 operand = 16'hAAAA; amt = 4'd0; oper = 2'b00;
        repeat (2) @(negedge clk);
        chk("bp_ov0", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_ov%0d", c + 1), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp_res%0d", c + 1), {16'b0, result}, 32'h1E1E);
            chk($sformatf("bp_rdy%0d", c + 1), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_ov", {31'b0, out_valid}, 32'd0);
        chk("bp_release_rdy", {31'b0, in_ready}, 32'd1);
        chk("bp_release_res", {16'b0, result}, 32'h1E1E);

        // Reset during STEP2 of a long shift: the in-flight operation is lost.
        @(negedge clk);
        in_valid = 1'b1; operand = 16'hFFFF; amt = 4'd15; oper = 2'b01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_res", {16'b0, result}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_noval", {31'b0, seen}, 32'd0);
        do_op(16'hF000, 4'd2, 2'b11, 16'h3C00, 2, "post_rst");

        // Random requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            rx = 16'($urandom);
            ra = int'($urandom_range(0, 15));
            ro = 2'($urandom);
            do_op(rx, 4'(ra), ro, ref_shift(rx, ra, ro), 1 + ra / 2 + ra % 2, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
